pwm_multi_channel: RTL and testbench
====================================

// Module: pwm_multi_channel
// PURPOSE
//  Multi-channel PWM generator; successor to the single-channel square-wave PWM.
//  One shared period counter with prescaler drives CH compare channels, each with a
//  shadowed duty register. Supports edge-aligned and center-aligned modes.
//  Sits between a simple register-write interface and output pins (LEDs, motor drivers).
// PARAMETERS
//  CH      4   number of PWM channels (>=1)
//  N       8   counter resolution in bits; duty is N+1 bits so 2^N gives full on
//  PRESC_W 16  prescaler width; one counter step every prescale+1 clocks
// PORTS
//  clk           in   1              system clock, all logic on rising edge
//  reset         in   1              synchronous, active-high reset
//  en            in   1              run enable
//  prescale      in   PRESC_W        clock divider; 0 = step every clock
//  mode          in   1              0 = edge-aligned, 1 = center-aligned
//  duty_wr_en    in   1              duty write strobe, one clock
//  duty_wr_ch    in   $clog2(CH)     channel index of write (width 1 when CH=1)
//  duty_wr_data  in   N+1            duty value, 0..2^N
//  pwm_out       out  CH             registered PWM outputs
//  period_tick   out  1              one-clock pulse at start of each period
// BEHAVIOUR
//  - Reset (sync, high): prescaler, counter, direction, pending and active duty, active mode,
//    pwm_out, period_tick all 0. Reset wins over every other input in the same cycle.
//  - Prescaler: counts 0..prescale; a "step" fires when it equals prescale, then clears.
//    prescale read live; if it drops below current count, step fires next clock and clears.
//  - Edge mode: on each step counter increments 0..2^N-1, wraps to 0. Period = 2^N steps.
//  - Center mode: up 0..2^N-1, then down 2^N-2..1, then 0 (up). Period = 2*(2^N-1) steps.
//  - Period boundary = a step that moves counter to 0 (wrap or down-count reaching 0).
//    At boundary: active_duty[i] <= pending_duty[i] for all i, active_mode <= mode,
//    direction <= up; period_tick pulses high the following clock (registered).
//  - Writes: duty_wr_en loads pending_duty[duty_wr_ch]; never alters active value mid-period.
//    Write coincident with boundary goes to pending only; takes effect at the next boundary.
//    duty_wr_ch >= CH ignored. duty_wr_data > 2^N saturates to 2^N.
//  - Compare: pwm_out[i] <= (counter < active_duty[i]), registered: 1 clock after counter.
//    duty 0 -> constantly low; duty 2^N -> constantly high (no glitch at wrap).
//  - en=0: prescaler, counter, direction held at 0; active_duty <= pending_duty and
//    active_mode <= mode every clock; pwm_out 0; period_tick 0. On en rising, first
//    counter value 0 is presented, next step at prescale+1 clocks later; no boundary tick
//    for the initial 0.
//  - Mode change while running: shadowed, applied only at boundary (no runt period).
//  - Counter width N, comparisons N+1 bit unsigned (counter zero-extended).
// STRUCTURE
//  - pwm_pkg: typedef pwm_mode_e {PWM_EDGE, PWM_CENTER}; duty width function/localparam.
//  - Top holds prescaler, shared counter/direction FSM (states UP, DOWN), boundary detect,
//    write decode, period_tick.
//  - Sub-module pwm_compare_ch (one per channel, generate loop): pending/active duty regs,
//    saturation, shadow load on boundary, registered compare output.
// TESTING  (CH=2, N=4, PRESC_W=8 unless noted)
//  1. prescale=0, mode=0, en=1, duty ch0=4 -> pwm_out[0] high 4 of every 16 clks;
//     period_tick every 16 clks; ch1 (duty 0) stays low.
//  2. duty ch0=16, ch1=0 -> pwm_out=2'b01 constant across >=3 wraps; duty 20 -> reads as 16.
//  3. ch1 duty 8, write 12 at count 5 -> that period high 8 clks, next period high 12 clks.
//  4. prescale=2, duty ch0=4 -> each count lasts 3 clks; period 48 clks, high 12 clks.
//  5. mode=1, duty ch0=4 -> period 30 clks, high 7 clks (counts 0-3 up, 3-1 down), symmetric.
//  6. reset asserted mid-period at count 9 -> next clock pwm_out=0, period_tick=0, counter 0;
//     after release with en=1, duty reads 0 (outputs low) until rewritten.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and width helpers for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_e;

  // Duty needs one extra bit so that 2^N encodes "always on".
  function automatic int unsigned duty_w(input int unsigned n);
    return n + 1;
  endfunction

  // Channel index width, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM channel: pending/active duty shadow pair and registered compare output.
module pwm_compare_ch
  import pwm_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         load_i,
  input  logic         wr_en_i,
  input  logic [N:0]   wr_data_i,
  input  logic [N-1:0] cnt_i,
  output logic         pwm_o
);

  localparam int unsigned   DW   = duty_w(N);
  localparam logic [DW-1:0] FULL = DW'(1) << N;

  logic [DW-1:0] pend_q, pend_d;
  logic [DW-1:0] act_q, act_d;
  logic          out_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      act_q  <= '0;
      pwm_o  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      pwm_o  <= out_d;
    end
  end

  // Active duty only changes from the pre-write pending value, so a write
  // landing on a load cycle waits for the following load.
  always_comb begin
    pend_d = pend_q;
    act_d  = act_q;
    out_d  = 1'b0;
    if (wr_en_i) pend_d = (wr_data_i > FULL) ? FULL : wr_data_i;
    if (load_i)  act_d  = pend_q;
    if (en_i)    out_d  = ({1'b0, cnt_i} < act_q);
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared prescaler and up/down period counter feeding
// per-channel shadowed compare units.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CH      = 4,
  parameter int unsigned N       = 8,
  parameter int unsigned PRESC_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [PRESC_W-1:0]      prescale,
  input  logic                    mode,
  input  logic                    duty_wr_en,
  input  logic [idx_w(CH)-1:0]    duty_wr_ch,
  input  logic [N:0]              duty_wr_data,
  output logic [CH-1:0]           pwm_out,
  output logic                    period_tick
);

  localparam int unsigned  CH_W    = idx_w(CH);
  localparam logic [N-1:0] CNT_MAX = '1;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [N-1:0]       cnt_q, cnt_d;
  pwm_dir_e           dir_q, dir_d;
  pwm_mode_e          mode_q, mode_d;
  logic               tick_d;
  logic               step_c;
  logic               boundary_c;
  logic               load_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      cnt_q       <= '0;
      dir_q       <= DIR_UP;
      mode_q      <= PWM_EDGE;
      period_tick <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      period_tick <= tick_d;
    end
  end

  // Counter direction FSM; a boundary is any step that lands on zero.
  always_comb begin
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    mode_d     = mode_q;
    tick_d     = 1'b0;
    step_c     = 1'b0;
    boundary_c = 1'b0;
    if (!en) begin
      presc_d = '0;
      cnt_d   = '0;
      dir_d   = DIR_UP;
      mode_d  = pwm_mode_e'(mode);
    end else begin
      step_c  = (presc_q >= prescale);
      presc_d = step_c ? '0 : presc_q + PRESC_W'(1);
      if (step_c) begin
        case (dir_q)
          DIR_UP: begin
            if (mode_q == PWM_CENTER && cnt_q == CNT_MAX) begin
              cnt_d = cnt_q - N'(1);
              dir_d = DIR_DOWN;
            end else begin
              cnt_d = cnt_q + N'(1);
            end
          end
          DIR_DOWN: cnt_d = cnt_q - N'(1);
          default:  cnt_d = '0;
        endcase
        boundary_c = (cnt_d == '0);
        if (boundary_c) begin
          dir_d  = DIR_UP;
          mode_d = pwm_mode_e'(mode);
          tick_d = 1'b1;
        end
      end
    end
  end

  assign load_c = !en || boundary_c;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_compare_ch #(.N(N)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .en_i      (en),
      .load_i    (load_c),
      .wr_en_i   (duty_wr_en && (duty_wr_ch == CH_W'(i))),
      .wr_data_i (duty_wr_data),
      .cnt_i     (cnt_q),
      .pwm_o     (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel (CH=2, N=4, PRESC_W=8) against a
// period-position reference model.
module tb_pwm_multi_channel;

  localparam int CH   = 2;
  localparam int N    = 4;
  localparam int PW   = 8;
  localparam int MAXC = (1 << N) - 1;
  localparam int FULL = 1 << N;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [PW-1:0] prescale;
  logic          mode;
  logic          duty_wr_en;
  logic [0:0]    duty_wr_ch;
  logic [N:0]    duty_wr_data;
  logic [CH-1:0] pwm_out;
  logic          period_tick;

  int n_checks = 0;
  int n_err    = 0;

  pwm_multi_channel #(.CH(CH), .N(N), .PRESC_W(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .prescale     (prescale),
    .mode         (mode),
    .duty_wr_en   (duty_wr_en),
    .duty_wr_ch   (duty_wr_ch),
    .duty_wr_data (duty_wr_data),
    .pwm_out      (pwm_out),
    .period_tick  (period_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position k within the period, counter value derived from k.
  int          m_div, m_k, m_mode_a;
  int          m_pend [CH];
  int          m_act  [CH];
  bit [CH-1:0] m_out;
  bit          m_tick;

  function automatic int cnt_of(input int k, input int md);
    if (md == 0) return k;
    return (k <= MAXC) ? k : 2 * MAXC - k;
  endfunction

  function automatic int per_of(input int md);
    return (md != 0) ? 2 * MAXC : MAXC + 1;
  endfunction

  always @(posedge clk) begin : model
    int          div_n, k_n, md_n;
    int          pend_n [CH];
    int          act_n  [CH];
    bit [CH-1:0] out_n;
    bit          tick_n;
    div_n  = m_div;
    k_n    = m_k;
    md_n   = m_mode_a;
    out_n  = '0;
    tick_n = 1'b0;
    for (int i = 0; i < CH; i++) begin
      pend_n[i] = m_pend[i];
      act_n[i]  = m_act[i];
    end
    if (reset) begin
      div_n = 0;
      k_n   = 0;
      md_n  = 0;
      for (int i = 0; i < CH; i++) begin
        pend_n[i] = 0;
        act_n[i]  = 0;
      end
    end else begin
      if (!en) begin
        div_n = 0;
        k_n   = 0;
        md_n  = mode ? 1 : 0;
        for (int i = 0; i < CH; i++) act_n[i] = m_pend[i];
      end else begin
        for (int i = 0; i < CH; i++) out_n[i] = (cnt_of(m_k, m_mode_a) < m_act[i]);
        if (m_div >= int'(prescale)) begin
          div_n = 0;
          k_n   = m_k + 1;
          if (k_n == per_of(m_mode_a)) begin
            k_n    = 0;
            tick_n = 1'b1;
            md_n   = mode ? 1 : 0;
            for (int i = 0; i < CH; i++) act_n[i] = m_pend[i];
          end
        end else begin
          div_n = m_div + 1;
        end
      end
      if (duty_wr_en && int'(duty_wr_ch) < CH)
        pend_n[int'(duty_wr_ch)] = (int'(duty_wr_data) > FULL) ? FULL : int'(duty_wr_data);
    end
    m_div    <= div_n;
    m_k      <= k_n;
    m_mode_a <= md_n;
    m_out    <= out_n;
    m_tick   <= tick_n;
    for (int i = 0; i < CH; i++) begin
      m_pend[i] <= pend_n[i];
      m_act[i]  <= act_n[i];
    end
  end

  // Stimulus helpers (no checking inside).
  task automatic write_duty(input int ch, input int data);
    duty_wr_en   = 1'b1;
    duty_wr_ch   = 1'(ch);
    duty_wr_data = (N+1)'(data);
    @(negedge clk);
    duty_wr_en   = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (period_tick === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic measure(input int n, output int hi0, output int hi1,
                         output int ticks, output int mism);
    hi0 = 0; hi1 = 0; ticks = 0; mism = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (pwm_out !== m_out || period_tick !== m_tick) mism++;
      if (pwm_out[0] === 1'b1) hi0++;
      if (pwm_out[1] === 1'b1) hi1++;
      if (period_tick === 1'b1) ticks++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; prescale = '0; mode = 1'b0;
    duty_wr_en = 1'b0; duty_wr_ch = '0; duty_wr_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pwm_out !== 2'b00 || period_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: pwm_out=%b tick=%b, expected 00 0", pwm_out, period_tick);
    end
    reset = 1'b0; en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_edge_basic();
    int hi0, hi1, tk, mm; bit ok;
    write_duty(0, 4);
    en = 1'b1;
    wait_tick(ok);
    n_checks++;
    if (!ok) begin n_err++; $display("FAIL edge_tick_timeout: no tick, expected one within 200 clks"); end
    measure(32, hi0, hi1, tk, mm);
    n_checks++;
    if (hi0 !== 8 || hi1 !== 0 || tk !== 2) begin
      n_err++;
      $display("FAIL edge_basic: hi0=%0d hi1=%0d ticks=%0d, expected 8 0 2", hi0, hi1, tk);
    end
    n_checks++;
    if (mm !== 0) begin n_err++; $display("FAIL edge_model: %0d cycle mismatches, expected 0", mm); end
  endtask

  task automatic test_saturation();
    int hi0, hi1, tk, mm; bit ok;
    write_duty(0, 16);
    write_duty(1, 0);
    wait_tick(ok);
    wait_tick(ok);
    measure(48, hi0, hi1, tk, mm);
    n_checks++;
    if (hi0 !== 48 || hi1 !== 0 || tk !== 3 || mm !== 0) begin
      n_err++;
      $display("FAIL full_duty: hi0=%0d hi1=%0d ticks=%0d mism=%0d, expected 48 0 3 0", hi0, hi1, tk, mm);
    end
    write_duty(0, 20);
    wait_tick(ok);
    wait_tick(ok);
    n_checks++;
    if (!ok) begin n_err++; $display("FAIL sat_tick_timeout: no tick, expected one"); end
    measure(16, hi0, hi1, tk, mm);
    n_checks++;
    if (hi0 !== 16 || tk !== 1 || mm !== 0) begin
      n_err++;
      $display("FAIL saturate: hi0=%0d ticks=%0d mism=%0d, expected 16 1 0", hi0, tk, mm);
    end
  endtask

  task automatic test_shadow();
    int h0a, h1a, tka, mma, h0b, h1b, tkb, mmb, h0c, h1c, tkc, mmc; bit ok;
    write_duty(1, 8);
    wait_tick(ok);
    wait_tick(ok);
    measure(5, h0a, h1a, tka, mma);
    duty_wr_en = 1'b1; duty_wr_ch = 1'b1; duty_wr_data = 5'd12;
    measure(1, h0b, h1b, tkb, mmb);
    duty_wr_en = 1'b0;
    h1a += h1b; mma += mmb; tka += tkb;
    measure(10, h0b, h1b, tkb, mmb);
    h1a += h1b; mma += mmb; tka += tkb;
    n_checks++;
    if (h1a !== 8 || tka !== 1 || mma !== 0) begin
      n_err++;
      $display("FAIL shadow_cur: hi1=%0d ticks=%0d mism=%0d, expected 8 1 0", h1a, tka, mma);
    end
    measure(16, h0c, h1c, tkc, mmc);
    n_checks++;
    if (h1c !== 12 || mmc !== 0) begin
      n_err++;
      $display("FAIL shadow_next: hi1=%0d mism=%0d, expected 12 0", h1c, mmc);
    end
  endtask

  task automatic test_prescale();
    int hi0, hi1, tk, mm; bit ok;
    prescale = 8'd2;
    write_duty(0, 4);
    wait_tick(ok);
    wait_tick(ok);
    n_checks++;
    if (!ok) begin n_err++; $display("FAIL presc_tick_timeout: no tick, expected one"); end
    measure(48, hi0, hi1, tk, mm);
    n_checks++;
    if (hi0 !== 12 || tk !== 1 || mm !== 0) begin
      n_err++;
      $display("FAIL prescale: hi0=%0d ticks=%0d mism=%0d, expected 12 1 0", hi0, tk, mm);
    end
    prescale = 8'd0;
  endtask

  task automatic test_center();
    int hi0, hi1, tk, mm; bit ok;
    mode = 1'b1;
    wait_tick(ok);
    measure(30, hi0, hi1, tk, mm);
    n_checks++;
    if (hi0 !== 7 || tk !== 1 || mm !== 0) begin
      n_err++;
      $display("FAIL center: hi0=%0d ticks=%0d mism=%0d, expected 7 1 0", hi0, tk, mm);
    end
    mode = 1'b0;
    wait_tick(ok);
    measure(16, hi0, hi1, tk, mm);
    n_checks++;
    if (hi0 !== 4 || tk !== 1 || mm !== 0) begin
      n_err++;
      $display("FAIL center_to_edge: hi0=%0d ticks=%0d mism=%0d, expected 4 1 0", hi0, tk, mm);
    end
  endtask

  task automatic test_reset_mid();
    int hi0, hi1, tk, mm; bit ok;
    write_duty(0, 8);
    wait_tick(ok);
    wait_tick(ok);
    measure(9, hi0, hi1, tk, mm);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pwm_out !== 2'b00 || period_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: pwm_out=%b tick=%b, expected 00 0", pwm_out, period_tick);
    end
    reset = 1'b0;
    measure(40, hi0, hi1, tk, mm);
    n_checks++;
    if (hi0 !== 0 || hi1 !== 0 || tk !== 2 || mm !== 0) begin
      n_err++;
      $display("FAIL reset_duty_clear: hi0=%0d hi1=%0d ticks=%0d mism=%0d, expected 0 0 2 0",
               hi0, hi1, tk, mm);
    end
  endtask

  task automatic test_random();
    int shown = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (en && $urandom_range(0, 99) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      if ($urandom_range(0, 149) == 0) prescale = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) mode = ~mode;
      duty_wr_en   = ($urandom_range(0, 9) == 0);
      duty_wr_ch   = 1'($urandom_range(0, 1));
      duty_wr_data = 5'($urandom_range(0, 31));
      @(negedge clk);
      n_checks++;
      if (pwm_out !== m_out || period_tick !== m_tick) begin
        n_err++;
        if (shown < 5)
          $display("FAIL random cyc %0d: pwm_out=%b tick=%b, expected %b %b",
                   c, pwm_out, period_tick, m_out, m_tick);
        shown++;
      end
    end
    reset = 1'b0; duty_wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_saturation();
    test_shadow();
    test_prescale();
    test_center();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
